pos_seq: RTL
============

# pos_seq

Parametrised position sequencer. Steps through a run-time writable table of WIDTH-bit positions, advancing one entry per `change` pulse. Supports loop, one-shot and ping-pong playback, with a programmable table length. Drives a sprite or camera coordinate (e.g. y-position) into the video/PicoBlaze user logic, and replaces fixed hard-coded position FSMs.

## Interface
- WIDTH, 10, bit width of each position value and of `o_signal`
- DEPTH, 32, number of table entries; AW = max(1, clog2(DEPTH))
- RESET_VALUE, 80, value driven on `o_signal` while in IDLE
- clk  input  1  rising-edge clock; the block uses one clock
- rst  input  1  reset; synchronous, active-high
- en  input  1  run enable; low pauses RUN, low in DONE returns to IDLE
- change  input  1  advance request, sampled every cycle, one step per high cycle
- restart  input  1  synchronous restart to index 0; table preserved
- mode  input  2  0 = LOOP, 1 = ONESHOT, 2 = PINGPONG, 3 = LOOP
- len  input  AW  index of last valid entry; values > DEPTH-1 are clamped to DEPTH-1
- wr_en  input  1  table write strobe
- wr_addr  input  AW  table write address; writes with wr_addr > DEPTH-1 are ignored
- wr_data  input  WIDTH  table write data
- o_signal  output  WIDTH  current position
- o_index  output  AW  current table index
- o_dir  output  1  0 = ascending, 1 = descending
- o_wrap  output  1  one-cycle pulse on wrap or reversal
- o_done  output  1  high in DONE

## Operation
- States: IDLE, RUN, DONE.
- Reset (rst high at a clock edge):
  - state = IDLE, index = 0, dir = 0, o_wrap = 0, o_done = 0.
  - Every table entry = 0.
  - `o_signal` = RESET_VALUE.
- IDLE:
  - `o_signal` = RESET_VALUE; `change` is ignored.
  - Goes to RUN on the first cycle with en = 1, at index 0, dir = 0.
- RUN:
  - `o_signal` = table[index], read combinationally from the registered index.
  - en = 0: hold index and `change` is ignored.
  - en = 1 and change = 1: step according to mode. L = clamped len. "At end" means index >= L.
- LOOP, on a step:
  - Not at end: index + 1.
  - At end: index = 0 and o_wrap pulses.
  - L = 0: index stays 0 and o_wrap pulses on every step.
- ONESHOT, on a step:
  - Not at end: index + 1.
  - At end: go to DONE, hold the index, o_wrap pulses.
- PINGPONG, on a step:
  - Ascending and not at end: index + 1.
  - Ascending and at end: dir = 1 and index - 1 (stays 0 if L = 0); o_wrap pulses.
  - Descending and index > 0: index - 1.
  - Descending and index = 0: dir = 0 and index + 1 (stays 0 if L = 0); o_wrap pulses.
  - Descending from index > L: keep decrementing; no reversal until index 0.
- DONE:
  - o_done = 1; `o_signal` holds table[index]; `change` is ignored.
  - en = 0 goes to IDLE.
  - Changing mode does not leave DONE.
- restart = 1 (en, change, mode ignored that cycle):
  - index = 0, dir = 0, o_done = 0.
  - State = RUN if en = 1, else IDLE.
- Mode change mid-run:
  - Takes effect on the next step; index is kept.
  - Leaving PINGPONG forces dir = 0 on the next step.
- len reduced below the current index:
  - LOOP: next step wraps to 0.
  - ONESHOT: next step goes to DONE.
  - PINGPONG: descends as above.
- Table writes: `wr_en` is accepted in every state, including during rst = 0 IDLE. `rst` overrides a write in the same cycle.

## Timing
- Index, dir, state and flags update on the clock edge after the cycle in which change / restart / en is sampled.
- o_signal changes combinationally with the index (zero added latency after the edge).
- A write to table[index]: o_signal shows the new value in the cycle after the write edge.
- Write and step in the same cycle: both happen. o_signal then reads the new index, including the newly written data if wr_addr equals the new index.
- o_wrap is high for exactly the one cycle following the stepping edge and is registered. Back-to-back wraps (L = 0, change held high) give o_wrap high continuously.
- Priority: rst > restart > en/change. `change` held high steps once per cycle.

## Test plan
- Reset, load table[0..3] = 100, 200, 300, 400, len = 3, mode LOOP, en = 1, four `change` pulses:
  - o_signal = 80 in IDLE, then 100, 200, 300, 400, then 100.
  - o_wrap is a one-cycle pulse at the wrap.
- ONESHOT with the same table: after 3 steps, index = 3 and o_done = 0. The 4th step gives DONE, o_done = 1, o_signal holds 400. Extra `change` has no effect. en = 0 gives IDLE and o_signal = 80.
- PINGPONG, len = 3, change held high 8 cycles: index sequence 0,1,2,3,2,1,0,1,2. o_wrap at the 3→2 and 0→1 steps; o_dir = 1 while descending.
- len = 0 in LOOP with change held: index stays 0, o_wrap is continuously high. Then len = 1 while index = 1 is reached, and len is set to 0: the next step goes to 0.
- restart asserted together with change at index 2, en = 1: index = 0, state RUN, no step taken. The same with en = 0 gives IDLE and o_signal = 80.
- Write wr_addr = current index, wr_data = 555, in the same cycle as a step: the step occurs and o_signal shows the table value at the new index. Rewriting the new index gives 555 in the following cycle. rst together with wr_en: the table entry reads 0.

Source files
------------

// File: rtl/pos_seq.sv
// Position sequencer: steps through a writable table of positions on each
// change pulse, with loop, one-shot and ping-pong playback.
module pos_seq #(
    parameter int WIDTH       = 10,
    parameter int DEPTH       = 32,
    parameter int RESET_VALUE = 80,
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             change,
    input  logic             restart,
    input  logic [1:0]       mode,
    input  logic [AW-1:0]    len,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] o_signal,
    output logic [AW-1:0]    o_index,
    output logic             o_dir,
    output logic             o_wrap,
    output logic             o_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [AW-1:0]     index_q, index_d;
    logic              dir_q, dir_d;
    logic              wrap_q, wrap_d;
    logic [WIDTH-1:0]  table_q [DEPTH];
    logic [DEPTH-1:0]  wr_sel;
    logic [AW-1:0]     len_c;
    logic              at_end;

    // Out-of-range write addresses match no entry and are dropped.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
        assign wr_sel[gi] = wr_en && (wr_addr == AW'(gi));
    end

    // The table is a register file because reset must clear every entry.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                table_q[i] <= '0;
            end else if (wr_sel[i]) begin
                table_q[i] <= wr_data;
            end
        end
    end

    assign len_c  = (len > LAST) ? LAST : len;
    assign at_end = (index_q >= len_c);

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        if (restart) begin
            index_d = '0;
            dir_d   = 1'b0;
            state_d = en ? S_RUN : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en) begin
                        state_d = S_RUN;
                        index_d = '0;
                        dir_d   = 1'b0;
                    end
                end
                S_RUN: begin
                    if (en && change) begin
                        case (mode)
                            2'd1: begin
                                dir_d = 1'b0;
                                if (at_end) begin
                                    state_d = S_DONE;
                                    wrap_d  = 1'b1;
                                end else begin
                                    index_d = index_q + AW'(1);
                                end
                            end
                            2'd2: begin
                                if (!dir_q) begin
                                    if (at_end) begin
                                        dir_d   = 1'b1;
                                        wrap_d  = 1'b1;
                                        index_d = (index_q == '0) ? '0 : index_q - AW'(1);
                                    end else begin
                                        index_d = index_q + AW'(1);
                                    end
                                end else if (index_q != '0) begin
                                    // Descending past a shrunk len keeps going down to 0.
                                    index_d = index_q - AW'(1);
                                end else begin
                                    dir_d   = 1'b0;
                                    wrap_d  = 1'b1;
                                    index_d = (len_c == '0) ? '0 : AW'(1);
                                end
                            end
                            default: begin
                                dir_d = 1'b0;
                                if (at_end) begin
                                    index_d = '0;
                                    wrap_d  = 1'b1;
                                end else begin
                                    index_d = index_q + AW'(1);
                                end
                            end
                        endcase
                    end
                end
                S_DONE: begin
                    if (!en) begin
                        state_d = S_IDLE;
                        index_d = '0;
                        dir_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    index_d = '0;
                    dir_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            index_q <= '0;
            dir_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
        end
    end

    assign o_signal = (state_q == S_IDLE) ? WIDTH'(RESET_VALUE) : table_q[index_q];
    assign o_index  = index_q;
    assign o_dir    = dir_q;
    assign o_wrap   = wrap_q;
    assign o_done   = (state_q == S_DONE);

endmodule
